// File: rtl/spi_xfer_pkg.sv
// ============================================================================
// spi_xfer_pkg: shared FSM state type and default timing constant for spi_xfer_master
// Revision 1.0
// ============================================================================
`default_nettype none

package spi_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        FIN   = 3'd4,
        GAP   = 3'd5
    } state_e;

    // 50 MHz system clock / (2*5) gives a 5 MHz SCLK
    localparam int unsigned c_clk_div_50mhz = 5;

endpackage

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// ============================================================================
// spi_sclk_gen: SCLK divider producing registered sclk and rise/fall strobes
// Revision 1.0
// ============================================================================
`default_nettype none

module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic shift_i,
    output logic sclk_o,
    output logic half_tick_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int unsigned           c_cnt_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_one  = c_cnt_w'(1);

    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               sclk_q, sclk_d;

    // Strobes mark the last clk cycle of a half period; sclk flips on the following edge
    assign half_tick_o = en_i && (cnt_q == c_cnt_last);
    assign rise_tick_o = half_tick_o && shift_i && !sclk_q;
    assign fall_tick_o = half_tick_o && shift_i && sclk_q;
    assign sclk_o      = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (half_tick_o) begin
            cnt_d = '0;
            if (shift_i) begin
                sclk_d = !sclk_q;
            end
        end else begin
            cnt_d = cnt_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_xfer_master.sv
// ============================================================================
// spi_xfer_master: mode-0 MSB-first SPI master, command phase then read phase.
// Optional auto-repeat of the last transaction: define SPI_XFER_AUTO_POLL_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module spi_xfer_master
    import spi_xfer_pkg::*;
#(
    parameter int unsigned CLK_DIV    = c_clk_div_50mhz,
    parameter int unsigned CMD_W      = 40,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned LEN_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CMD_W-1:0]  cmd_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [LEN_W-1:0]  rd_len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              ssb_o
);

    localparam int unsigned        c_cnt_max   = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned        c_cnt_w     = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [LEN_W:0]     c_bit_one   = (LEN_W+1)'(1);
    localparam logic [LEN_W-1:0]   c_cmd_max   = LEN_W'(CMD_W);
    localparam logic [LEN_W-1:0]   c_rd_max    = LEN_W'(DATA_W);

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ssb_q, ssb_d;
    logic                mosi_q, mosi_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [DATA_W-1:0]   rd_sr_q, rd_sr_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [CMD_W-1:0]    cmd_sr_q, cmd_sr_d;
    logic [LEN_W-1:0]    cmd_len_q, cmd_len_d;
    logic [LEN_W-1:0]    rd_len_q, rd_len_d;
    logic [LEN_W:0]      bit_cnt_q, bit_cnt_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;

    logic                w_sclk_en;
    logic                w_shift;
    logic                w_half;
    logic                w_rise;
    logic                w_fall;
    logic [LEN_W-1:0]    w_cmd_len_sat;
    logic [LEN_W-1:0]    w_rd_len_sat;
    logic [LEN_W:0]      w_total;
    logic [LEN_W:0]      w_bit_next;
    logic                w_launch;
    logic [CMD_W-1:0]    w_l_cmd;
    logic [LEN_W-1:0]    w_l_cmd_len;
    logic [LEN_W-1:0]    w_l_rd_len;

    assign w_sclk_en     = (state_q == SETUP) || (state_q == SHIFT);
    assign w_shift       = (state_q == SHIFT);
    assign w_cmd_len_sat = (cmd_len_i > c_cmd_max) ? c_cmd_max : cmd_len_i;
    assign w_rd_len_sat  = (rd_len_i > c_rd_max) ? c_rd_max : rd_len_i;
    assign w_total       = {1'b0, cmd_len_q} + {1'b0, rd_len_q};
    assign w_bit_next    = bit_cnt_q + c_bit_one;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk         (clk),
        .rst         (rst),
        .en_i        (w_sclk_en),
        .shift_i     (w_shift),
        .sclk_o      (sclk_o),
        .half_tick_o (w_half),
        .rise_tick_o (w_rise),
        .fall_tick_o (w_fall)
    );

    // Chooses whether a transaction starts this cycle, and with which parameters
    always_comb begin
        w_launch    = 1'b0;
        w_l_cmd     = cmd_q;
        w_l_cmd_len = cmd_len_q;
        w_l_rd_len  = rd_len_q;
        if ((state_q == IDLE) && start_i) begin
            w_launch    = 1'b1;
            w_l_cmd     = cmd_i;
            w_l_cmd_len = w_cmd_len_sat;
            w_l_rd_len  = w_rd_len_sat;
        end
`ifdef SPI_XFER_AUTO_POLL_EN
        else if ((state_q == GAP) && (cnt_q == c_gap_last)) begin
            w_launch = 1'b1;
            if (start_i) begin
                w_l_cmd     = cmd_i;
                w_l_cmd_len = w_cmd_len_sat;
                w_l_rd_len  = w_rd_len_sat;
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ssb_d     = ssb_q;
        mosi_d    = mosi_q;
        rd_data_d = rd_data_q;
        rd_sr_d   = rd_sr_q;
        cmd_d     = cmd_q;
        cmd_sr_d  = cmd_sr_q;
        cmd_len_d = cmd_len_q;
        rd_len_d  = rd_len_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
            end
            SETUP: begin
                if (w_half) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (w_rise && (bit_cnt_q >= {1'b0, cmd_len_q})) begin
                    rd_sr_d = {rd_sr_q[DATA_W-2:0], miso_i};
                end
                if (w_fall) begin
                    bit_cnt_d = w_bit_next;
                    cmd_sr_d  = cmd_sr_q << 1;
                    mosi_d    = (w_bit_next < {1'b0, cmd_len_q}) ? cmd_sr_q[CMD_W-1] : 1'b0;
                    if (w_bit_next == w_total) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == c_hold_last) begin
                    state_d = FIN;
                    ssb_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            FIN: begin
                done_d    = 1'b1;
                rd_data_d = rd_sr_q;
                state_d   = GAP;
                cnt_d     = '0;
            end
            GAP: begin
                if (cnt_q == c_gap_last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // cmd_sr holds the bits after the one already on mosi
        if (w_launch) begin
            busy_d    = 1'b1;
            cmd_d     = w_l_cmd;
            cmd_len_d = w_l_cmd_len;
            rd_len_d  = w_l_rd_len;
            cmd_sr_d  = w_l_cmd << 1;
            rd_sr_d   = '0;
            bit_cnt_d = '0;
            cnt_d     = '0;
            if ((w_l_cmd_len == '0) && (w_l_rd_len == '0)) begin
                state_d = FIN;
            end else begin
                state_d = SETUP;
                ssb_d   = 1'b0;
                mosi_d  = (w_l_cmd_len != '0) ? w_l_cmd[CMD_W-1] : 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ssb_q     <= 1'b1;
            mosi_q    <= 1'b0;
            rd_data_q <= '0;
            rd_sr_q   <= '0;
            cmd_q     <= '0;
            cmd_sr_q  <= '0;
            cmd_len_q <= '0;
            rd_len_q  <= '0;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ssb_q     <= ssb_d;
            mosi_q    <= mosi_d;
            rd_data_q <= rd_data_d;
            rd_sr_q   <= rd_sr_d;
            cmd_q     <= cmd_d;
            cmd_sr_q  <= cmd_sr_d;
            cmd_len_q <= cmd_len_d;
            rd_len_q  <= rd_len_d;
            bit_cnt_q <= bit_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rd_data_o = rd_data_q;
    assign mosi_o    = mosi_q;
    assign ssb_o     = ssb_q;

endmodule

`default_nettype wire
